// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and registers the fetched word into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 8192,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        if_id_fault_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] LAST_FETCH = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        fault;

  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_fault_q, ifid_fault_d;
  logic [31:0] count_q, count_d;

  assign pc_plus4 = pc_q + 32'd4;
  assign fault    = (pc_q[1:0] != 2'b00) || (pc_q > LAST_FETCH);

  // A faulting PC is replaced by address 0 so the memory never sees an
  // out-of-range index; the fetched word is discarded in that case anyway.
  assign imem_addr_o = fault ? 32'd0 : pc_q;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_fault_d = ifid_fault_q;
    count_d      = count_q;
    if (redirect_valid_i || flush_i) begin
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      ifid_fault_d = 1'b0;
    end else if (!stall_i) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = fault ? NOP_INSTR : imem_data_i;
      ifid_valid_d = 1'b1;
      ifid_fault_d = fault;
      if (!fault) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_fault_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_fault_q <= ifid_fault_d;
      count_q      <= count_d;
    end
  end

  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_pc4_o   = ifid_pc4_q;
  assign if_id_instr_o = ifid_instr_q;
  assign if_id_valid_o = ifid_valid_q;
  assign if_id_fault_o = ifid_fault_q;
  assign fetch_count_o = count_q;

endmodule
